// File: rtl/schedule_pkg.sv
// schedule_pkg: FSM states and widths shared by the schedule sequencer and its table.
package schedule_pkg;
    localparam int SCHED_W       = 32;
    localparam int DEFAULT_DEPTH = 16;
    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;
endpackage

// File: rtl/schedule_table.sv
// schedule_table: schedule RAM with synchronous write and a registered, clearable read port.
module schedule_table
    import schedule_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_wr_en,
    input  logic [AW-1:0]      i_wr_addr,
    input  logic [SCHED_W-1:0] i_wr_data,
    input  logic               i_rd_en,
    input  logic               i_rd_clr,
    input  logic [AW-1:0]      i_rd_addr,
    output logic [SCHED_W-1:0] o_rd_data
);
    logic [SCHED_W-1:0] r_mem [DEPTH];
    logic [SCHED_W-1:0] r_rd_data;

    // Storage is deliberately left out of reset so the schedule survives it.
    always_ff @(posedge clk) begin
        if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    end

    always_ff @(posedge clk) begin
        if (!rst || i_rd_clr) r_rd_data <= '0;
        else if (i_rd_en)     r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;
endmodule

// File: rtl/schedule_sequencer.sv
// schedule_sequencer: steps through a table of schedule times, advancing on each comparator match.
// Define SCHED_MISS_DETECT_EN to add the GTB input and auto-advance on a missed (already past) slot.
module schedule_sequencer
    import schedule_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic [AW:0]        num_entries,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [SCHED_W-1:0] wr_data,
    input  logic               trigger,
    output logic [SCHED_W-1:0] schedule,
    output logic [AW-1:0]      slot_idx,
    output logic               slot_valid,
    output logic               cycle_done,
    output logic               wr_err
`ifdef SCHED_MISS_DETECT_EN
    ,
    input  logic [SCHED_W-1:0] GTB,
    output logic               miss
`endif
);
    state_t        r_state;
    logic [AW-1:0] r_slot;
    logic [AW:0]   r_num;
    logic          r_valid;
    logic          r_cycle_done;
    logic          r_wr_err;
    logic          w_num_ok;
    logic          w_wrap;
    logic          w_late;
    logic          w_adv;
    logic [AW-1:0] w_next;

    assign w_num_ok = num_entries != '0 && num_entries <= (AW+1)'(DEPTH);
    assign w_wrap   = {1'b0, r_slot} == r_num - (AW+1)'(1);
    assign w_next   = w_wrap ? '0 : r_slot + AW'(1);

`ifdef SCHED_MISS_DETECT_EN
    logic [SCHED_W-1:0] w_diff;
    logic               r_miss;
    // GTB strictly ahead of the slot time (by less than half the range) means the match was missed.
    assign w_diff = GTB - schedule;
    assign w_late = !trigger && w_diff != '0 && !w_diff[SCHED_W-1];
    assign miss   = r_miss;
`else
    assign w_late = 1'b0;
`endif

    assign w_adv = run && r_state == RUN && (trigger || w_late);

    schedule_table #(.DEPTH(DEPTH), .AW(AW)) u_table (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (wr_en && r_state == IDLE),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_rd_en   (run && (r_state == PRIME || w_adv)),
        .i_rd_clr  (!run),
        .i_rd_addr (r_state == PRIME ? '0 : w_next),
        .o_rd_data (schedule)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_slot       <= '0;
            r_num        <= '0;
            r_valid      <= 1'b0;
            r_cycle_done <= 1'b0;
            r_wr_err     <= 1'b0;
`ifdef SCHED_MISS_DETECT_EN
            r_miss       <= 1'b0;
`endif
        end else begin
            r_wr_err     <= wr_en && r_state != IDLE;
            r_cycle_done <= w_adv && w_wrap;
`ifdef SCHED_MISS_DETECT_EN
            r_miss       <= w_adv && !trigger;
`endif
            if (!run) begin
                r_state <= IDLE;
                r_slot  <= '0;
                r_valid <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_num_ok) begin
                            r_state <= PRIME;
                            r_num   <= num_entries;
                        end
                    end
                    PRIME: begin
                        r_state <= RUN;
                        r_slot  <= '0;
                        r_valid <= 1'b1;
                    end
                    RUN: begin
                        if (w_adv) r_slot <= w_next;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign slot_idx   = r_slot;
    assign slot_valid = r_valid;
    assign cycle_done = r_cycle_done;
    assign wr_err     = r_wr_err;
endmodule
